pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock, then releases the system reset.
// Optional lock statistics (lol_cnt, last_lock_time) are enabled by defining PLL_LOCK_STATS_EN.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        soft_req,
    output logic        pll_rst,
    output logic        sys_rst_n,
    output logic        ready,
    output logic        fail,
    output logic [3:0]  retry_cnt
`ifdef PLL_LOCK_STATS_EN
    ,
    output logic [7:0]  lol_cnt,
    output logic [15:0] last_lock_time
`endif
);

    localparam int unsigned HOLD_W = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
    localparam int unsigned WAIT_W = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [3:0]          retry_cnt_q, retry_cnt_d;
    logic [3:0]          retry_inc;
    logic                locked_s;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic                ready_q, ready_d;
    logic                fail_q, fail_d;
`ifdef PLL_LOCK_STATS_EN
    logic [7:0]          lol_cnt_q, lol_cnt_d;
    logic [15:0]         last_lock_time_q, last_lock_time_d;
`endif

    assign locked_s  = sync_q[1];
    assign retry_inc = retry_cnt_q + 4'd1;

    // State, counter and output registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_HOLD;
            sync_q           <= 2'b00;
            hold_cnt_q       <= '0;
            wait_cnt_q       <= '0;
            stab_cnt_q       <= '0;
            retry_cnt_q      <= 4'd0;
            pll_rst_q        <= 1'b1;
            sys_rst_n_q      <= 1'b0;
            ready_q          <= 1'b0;
            fail_q           <= 1'b0;
`ifdef PLL_LOCK_STATS_EN
            lol_cnt_q        <= 8'd0;
            last_lock_time_q <= 16'd0;
`endif
        end else begin
            state_q          <= state_d;
            sync_q           <= sync_d;
            hold_cnt_q       <= hold_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            stab_cnt_q       <= stab_cnt_d;
            retry_cnt_q      <= retry_cnt_d;
            pll_rst_q        <= pll_rst_d;
            sys_rst_n_q      <= sys_rst_n_d;
            ready_q          <= ready_d;
            fail_q           <= fail_d;
`ifdef PLL_LOCK_STATS_EN
            lol_cnt_q        <= lol_cnt_d;
            last_lock_time_q <= last_lock_time_d;
`endif
        end
    end

    // Next state; each counter defaults to zero so it only runs in its own state
    always_comb begin
        state_d          = state_q;
        sync_d           = {sync_q[0], pll_locked};
        hold_cnt_d       = '0;
        wait_cnt_d       = '0;
        stab_cnt_d       = '0;
        retry_cnt_d      = retry_cnt_q;
`ifdef PLL_LOCK_STATS_EN
        lol_cnt_d        = lol_cnt_q;
        last_lock_time_d = last_lock_time_q;
`endif
        if (soft_req) begin
            state_d     = S_HOLD;
            retry_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
                    else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                S_WAIT_LOCK: begin
                    // Lock takes priority over a timeout expiring in the same cycle
                    if (locked_s) begin
                        state_d = S_STABLE;
`ifdef PLL_LOCK_STATS_EN
                        last_lock_time_d = 16'(wait_cnt_q);
`endif
                    end else if (wait_cnt_q == WAIT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_cnt_d = retry_inc;
                        state_d     = (retry_inc == 4'(MAX_RETRIES)) ? S_FAIL : S_HOLD;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) state_d = S_WAIT_LOCK;
                    else if (stab_cnt_q == STAB_W'(STABLE_CYCLES - 1)) state_d = S_RUN;
                    else stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d     = S_HOLD;
                        retry_cnt_d = 4'd0;
`ifdef PLL_LOCK_STATS_EN
                        if (lol_cnt_q != 8'hFF) lol_cnt_d = lol_cnt_q + 8'd1;
`endif
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_HOLD;
            endcase
        end
    end

    // Outputs decoded from the next state so they register in step with it
    always_comb begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fail_d      = 1'b0;
        unique case (state_d)
            S_HOLD:  pll_rst_d = 1'b1;
            S_RUN: begin
                sys_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            S_FAIL:  fail_d = 1'b1;
            default: ;
        endcase
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;
`ifdef PLL_LOCK_STATS_EN
    assign lol_cnt        = lol_cnt_q;
    assign last_lock_time = last_lock_time_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer (RST=4, TIMEOUT=100, STABLE=8, RETRIES=2).
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
`ifdef PLL_LOCK_STATS_EN
    logic [7:0]  lol_cnt;
    logic [15:0] last_lock_time;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .soft_req  (soft_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt)
`ifdef PLL_LOCK_STATS_EN
        ,
        .lol_cnt       (lol_cnt),
        .last_lock_time(last_lock_time)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b0; soft_req = 1'b0;
        repeat (3) @(negedge refclk);
        n_checks++; if (pll_rst !== 1'b1)   begin n_fail++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        n_checks++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
        n_checks++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL reset_fail got %b want 0", fail); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
    endtask

    task automatic test_lock_sequence();
        int hi;
        int n;
        hi = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pll_rst) hi++;
            @(negedge refclk);
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL seq_pll_rst_width got %0d want 4", hi); end
        pll_locked = 1'b1;
        n = 0;
        while (!sys_rst_n && n < 50) begin @(negedge refclk); n++; end
        n_checks++; if (n < 9 || n > 11) begin n_fail++; $display("FAIL seq_release_latency got %0d want 9..11", n); end
        n_checks++; if (ready !== 1'b1)     begin n_fail++; $display("FAIL seq_ready got %b want 1", ready); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL seq_retry got %0d want 0", retry_cnt); end
        n_checks++; if (pll_rst !== 1'b0)   begin n_fail++; $display("FAIL seq_pll_rst got %b want 0", pll_rst); end
    endtask

    task automatic test_timeout_fail();
        int h1, l1, h2, l2;
        h1 = 0; l1 = 0; h2 = 0; l2 = 0;
        pll_locked = 1'b0;
        soft_req   = 1'b1;
        @(negedge refclk);
        soft_req = 1'b0;
        while (pll_rst && h1 < 20)                 begin h1++; @(negedge refclk); end
        while (!pll_rst && !fail && l1 < 200)      begin l1++; @(negedge refclk); end
        while (pll_rst && h2 < 20)                 begin h2++; @(negedge refclk); end
        while (!pll_rst && !fail && l2 < 200)      begin l2++; @(negedge refclk); end
        n_checks++; if (h1 != 4)   begin n_fail++; $display("FAIL to_hold1 got %0d want 4", h1); end
        n_checks++; if (l1 != 100) begin n_fail++; $display("FAIL to_window1 got %0d want 100", l1); end
        n_checks++; if (h2 != 4)   begin n_fail++; $display("FAIL to_hold2 got %0d want 4", h2); end
        n_checks++; if (l2 != 100) begin n_fail++; $display("FAIL to_window2 got %0d want 100", l2); end
        n_checks++; if (fail !== 1'b1)      begin n_fail++; $display("FAIL to_fail got %b want 1", fail); end
        n_checks++; if (retry_cnt !== 4'd2) begin n_fail++; $display("FAIL to_retry got %0d want 2", retry_cnt); end
        n_checks++; if (pll_rst !== 1'b0)   begin n_fail++; $display("FAIL to_pll_rst got %b want 0", pll_rst); end
        repeat (5) @(negedge refclk);
        n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL to_fail_sticky got %b want 1", fail); end
        soft_req = 1'b1;
        @(negedge refclk);
        soft_req = 1'b0;
        n_checks++; if (fail !== 1'b0)      begin n_fail++; $display("FAIL to_soft_fail got %b want 0", fail); end
        n_checks++; if (pll_rst !== 1'b1)   begin n_fail++; $display("FAIL to_soft_pll_rst got %b want 1", pll_rst); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL to_soft_retry got %0d want 0", retry_cnt); end
    endtask

    task automatic test_stable_glitch();
        int n;
        int w;
        logic pulse_seen;
        w = 0;
        while (pll_rst && w < 20) begin @(negedge refclk); w++; end
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        n = 0;
        pulse_seen = 1'b0;
        while (!sys_rst_n && n < 60) begin
            if (n == 7) pll_locked = 1'b0;
            if (n == 8) pll_locked = 1'b1;
            @(negedge refclk);
            n++;
            if (pll_rst) pulse_seen = 1'b1;
        end
        n_checks++; if (pulse_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_pll_rst_pulse got %b want 0", pulse_seen); end
        n_checks++; if (n < 18 || n > 20)    begin n_fail++; $display("FAIL glitch_release_latency got %0d want 18..20", n); end
        n_checks++; if (retry_cnt !== 4'd0)  begin n_fail++; $display("FAIL glitch_retry got %0d want 0", retry_cnt); end
    endtask

    task automatic test_run_lol();
        int n;
        int h;
        pll_locked = 1'b0;
        n = 0;
        while (sys_rst_n && n < 20) begin @(negedge refclk); n++; end
        n_checks++; if (n < 2 || n > 3)   begin n_fail++; $display("FAIL lol_latency got %0d want 2..3", n); end
        n_checks++; if (ready !== 1'b0)   begin n_fail++; $display("FAIL lol_ready got %b want 0", ready); end
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL lol_pll_rst got %b want 1", pll_rst); end
        h = 0;
        while (pll_rst && h < 20) begin h++; @(negedge refclk); end
        n_checks++; if (h != 4) begin n_fail++; $display("FAIL lol_hold_width got %0d want 4", h); end
        pll_locked = 1'b1;
        n = 0;
        while (!sys_rst_n && n < 50) begin @(negedge refclk); n++; end
        n_checks++; if (ready !== 1'b1)     begin n_fail++; $display("FAIL lol_reseq_ready got %b want 1", ready); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL lol_reseq_retry got %0d want 0", retry_cnt); end
`ifdef PLL_LOCK_STATS_EN
        n_checks++; if (lol_cnt !== 8'd1)  begin n_fail++; $display("FAIL lol_cnt got %0d want 1", lol_cnt); end
        n_checks++; if (last_lock_time !== 16'd2) begin n_fail++; $display("FAIL last_lock_time got %0d want 2", last_lock_time); end
`endif
    endtask

    task automatic test_async_reset();
        int w;
        soft_req = 1'b1;
        @(negedge refclk);
        soft_req = 1'b0;
        w = 0;
        while (pll_rst && w < 20) begin @(negedge refclk); w++; end
        repeat (3) @(negedge refclk);
        n_checks++; if (sys_rst_n !== 1'b0 || pll_rst !== 1'b0) begin
            n_fail++; $display("FAIL areset_pre_stable got sys_rst_n=%b pll_rst=%b want 0/0", sys_rst_n, pll_rst);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pll_rst !== 1'b1)   begin n_fail++; $display("FAIL areset_pll_rst got %b want 1", pll_rst); end
        n_checks++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL areset_sys_rst_n got %b want 0", sys_rst_n); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL areset_retry got %0d want 0", retry_cnt); end
    endtask

    task automatic test_soft_at_timeout();
        int w;
        pll_locked = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;
        w = 0;
        while (pll_rst && w < 20) begin @(negedge refclk); w++; end
        repeat (99) @(negedge refclk);
        n_checks++; if (pll_rst !== 1'b0 || retry_cnt !== 4'd0) begin
            n_fail++; $display("FAIL soft_to_pre got pll_rst=%b retry=%0d want 0/0", pll_rst, retry_cnt);
        end
        soft_req = 1'b1;
        @(negedge refclk);
        soft_req = 1'b0;
        n_checks++; if (pll_rst !== 1'b1)   begin n_fail++; $display("FAIL soft_to_hold got %b want 1", pll_rst); end
        n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL soft_to_retry got %0d want 0", retry_cnt); end
        w = 0;
        while (pll_rst && w < 20) begin @(negedge refclk); w++; end
        repeat (100) @(negedge refclk);
        n_checks++; if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL plain_to_retry got %0d want 1", retry_cnt); end
        n_checks++; if (pll_rst !== 1'b1)   begin n_fail++; $display("FAIL plain_to_hold got %b want 1", pll_rst); end
    endtask

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; soft_req = 1'b0;
        test_reset();
        test_lock_sequence();
        test_timeout_fail();
        test_stable_glitch();
        test_run_lol();
        test_async_reset();
        test_soft_at_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
